// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-master RAM arbiter: FSM states and requester IDs.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RWAIT  = 2'd2
  } state_e;

  typedef enum logic {
    ID_CPU = 1'b0,
    ID_DMA = 1'b1
  } req_id_e;

  localparam int NUM_REQ = 2;

  function automatic req_id_e other_id(req_id_e id);
    return (id == ID_CPU) ? ID_DMA : ID_CPU;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of both requester handshakes plus the RAM pins. slave = arbiter side.
interface ram_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic              mem_we;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_dout,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_din, mem_we
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_dout,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational 2-way pick; on contention either alternates or favours the cpu.
module rr_arb2
  import ram_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic    req_a_i,
  input  logic    req_b_i,
  input  req_id_e last_grant_i,
  output req_id_e grant_id_o
);

  always_comb begin
    grant_id_o = ID_CPU;
    if (req_a_i && req_b_i)
      grant_id_o = (ROUND_ROBIN != 0) ? other_id(last_grant_i) : ID_CPU;
    else if (req_b_i)
      grant_id_o = ID_DMA;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises cpu and dma accesses onto one single-port RAM:
// IDLE -> ACCESS -> (write) IDLE | (read) RWAIT -> IDLE.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int READ_LAT    = 1,
  parameter int ROUND_ROBIN = 1
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus,
  output logic          busy
);

  localparam int               CNT_W    = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  state_e                          state_q;
  req_id_e                         owner_q, last_q, grant_id;
  logic [CNT_W-1:0]                cnt_q;
  logic [ADDR_W-1:0]               addr_q;
  logic [DATA_W-1:0]               din_q;
  logic                            mem_we_q;
  logic [NUM_REQ-1:0]              gnt_q, rvalid_q;
  logic [NUM_REQ-1:0][DATA_W-1:0]  rdata_q;

  logic              any_req, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .req_a_i      (bus.cpu_req),
    .req_b_i      (bus.dma_req),
    .last_grant_i (last_q),
    .grant_id_o   (grant_id)
  );

  always_comb begin
    any_req   = bus.cpu_req | bus.dma_req;
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    if (grant_id == ID_DMA) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end
  end

  // gnt/rvalid/mem_we are single-cycle pulses: cleared every edge unless re-set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= ID_CPU;
      last_q   <= ID_DMA;
      cnt_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      mem_we_q <= 1'b0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      mem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            addr_q          <= sel_addr;
            din_q           <= sel_wdata;
            mem_we_q        <= sel_we;
            owner_q         <= grant_id;
            last_q          <= grant_id;
            gnt_q[grant_id] <= 1'b1;
            state_q         <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          cnt_q   <= '0;
          state_q <= mem_we_q ? S_IDLE : S_RWAIT;
        end
        S_RWAIT: begin
          if (cnt_q == CNT_LAST) begin
            rdata_q[owner_q]  <= bus.mem_dout;
            rvalid_q[owner_q] <= 1'b1;
            state_q           <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_gnt    = gnt_q[ID_CPU];
  assign bus.dma_gnt    = gnt_q[ID_DMA];
  assign bus.cpu_rvalid = rvalid_q[ID_CPU];
  assign bus.dma_rvalid = rvalid_q[ID_DMA];
  assign bus.cpu_rdata  = rdata_q[ID_CPU];
  assign bus.dma_rdata  = rdata_q[ID_DMA];
  assign bus.mem_addr   = addr_q;
  assign bus.mem_din    = din_q;
  assign bus.mem_we     = mem_we_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: unit 0 = RR/lat1, unit 1 = fixed-priority/lat1, unit 2 = RR/lat3.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  logic       cpu_req [3], cpu_we [3], dma_req [3], dma_we [3];
  logic [7:0] cpu_addr [3], cpu_wdata [3], dma_addr [3], dma_wdata [3];
  logic       cpu_gnt [3], cpu_rvalid [3], dma_gnt [3], dma_rvalid [3];
  logic [7:0] cpu_rdata [3], dma_rdata [3];
  logic [7:0] mem_addr [3], mem_din [3];
  logic       mem_we [3], busy [3];

  ram_arbiter_if #(.DATA_W(8), .ADDR_W(8)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : gu
    localparam int RL = (g == 2) ? 3 : 1;

    ram_arbiter #(
      .DATA_W(8), .ADDR_W(8), .READ_LAT(RL), .ROUND_ROBIN((g == 1) ? 0 : 1)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g]),
      .busy  (busy[g])
    );

    assign bus[g].cpu_req   = cpu_req[g];
    assign bus[g].cpu_we    = cpu_we[g];
    assign bus[g].cpu_addr  = cpu_addr[g];
    assign bus[g].cpu_wdata = cpu_wdata[g];
    assign bus[g].dma_req   = dma_req[g];
    assign bus[g].dma_we    = dma_we[g];
    assign bus[g].dma_addr  = dma_addr[g];
    assign bus[g].dma_wdata = dma_wdata[g];
    assign cpu_gnt[g]    = bus[g].cpu_gnt;
    assign cpu_rvalid[g] = bus[g].cpu_rvalid;
    assign cpu_rdata[g]  = bus[g].cpu_rdata;
    assign dma_gnt[g]    = bus[g].dma_gnt;
    assign dma_rvalid[g] = bus[g].dma_rvalid;
    assign dma_rdata[g]  = bus[g].dma_rdata;
    assign mem_addr[g]   = bus[g].mem_addr;
    assign mem_din[g]    = bus[g].mem_din;
    assign mem_we[g]     = bus[g].mem_we;

    // RAM model: addr sampled every edge, dout valid RL edges later.
    logic [7:0] mem [256];
    logic [7:0] pipe [3];
    always @(posedge clk) begin
      if (bus[g].mem_we) mem[bus[g].mem_addr] <= bus[g].mem_din;
      pipe[0] <= mem[bus[g].mem_addr];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign bus[g].mem_dout = pipe[RL-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int u, bit p, logic r, logic w, logic [7:0] a, logic [7:0] d);
    if (p) begin
      dma_req[u] = r; dma_we[u] = w; dma_addr[u] = a; dma_wdata[u] = d;
    end else begin
      cpu_req[u] = r; cpu_we[u] = w; cpu_addr[u] = a; cpu_wdata[u] = d;
    end
  endtask

  function automatic logic gnt_of(int u, bit p);
    return p ? dma_gnt[u] : cpu_gnt[u];
  endfunction
  function automatic logic rv_of(int u, bit p);
    return p ? dma_rvalid[u] : cpu_rvalid[u];
  endfunction
  function automatic logic [7:0] rd_of(int u, bit p);
    return p ? dma_rdata[u] : cpu_rdata[u];
  endfunction

  task automatic wr(int u, bit p, logic [7:0] a, logic [7:0] d);
    drive(u, p, 1'b1, 1'b1, a, d);
    tick();
    chk($sformatf("u%0d p%0d wr gnt", u, p), gnt_of(u, p), 1);
    chk($sformatf("u%0d wr mem_we", u), mem_we[u], 1);
    chk($sformatf("u%0d wr mem_addr", u), mem_addr[u], a);
    chk($sformatf("u%0d wr mem_din", u), mem_din[u], d);
    drive(u, p, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk($sformatf("u%0d wr gnt drop", u), gnt_of(u, p), 0);
    chk($sformatf("u%0d wr mem_we drop", u), mem_we[u], 0);
    chk($sformatf("u%0d wr busy", u), busy[u], 0);
  endtask

  task automatic rd(int u, bit p, logic [7:0] a, logic [7:0] exp, int rl);
    drive(u, p, 1'b1, 1'b0, a, 8'h00);
    tick();
    chk($sformatf("u%0d p%0d rd gnt", u, p), gnt_of(u, p), 1);
    chk($sformatf("u%0d rd mem_we", u), mem_we[u], 0);
    drive(u, p, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (rl) begin
      tick();
      chk($sformatf("u%0d rd early rvalid", u), rv_of(u, p), 0);
      chk($sformatf("u%0d rd busy", u), busy[u], 1);
    end
    tick();
    chk($sformatf("u%0d p%0d rd rvalid", u, p), rv_of(u, p), 1);
    chk($sformatf("u%0d p%0d rd rdata", u, p), rd_of(u, p), exp);
    chk($sformatf("u%0d rd idle", u), busy[u], 0);
    tick();
    chk($sformatf("u%0d rd rvalid pulse", u), rv_of(u, p), 0);
  endtask

  // Both ports read (cpu 0x20, dma 0x21) in the same cycle; READ_LAT=1 units only.
  task automatic both(int u, bit first, logic [7:0] cexp, logic [7:0] dexp);
    bit second = ~first;
    drive(u, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
    drive(u, 1'b1, 1'b1, 1'b0, 8'h21, 8'h00);
    tick();
    chk($sformatf("u%0d both first gnt", u), gnt_of(u, first), 1);
    chk($sformatf("u%0d both second held", u), gnt_of(u, second), 0);
    drive(u, first, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk($sformatf("u%0d both first rvalid", u), rv_of(u, first), 1);
    chk($sformatf("u%0d both first rdata", u), rd_of(u, first), first ? dexp : cexp);
    tick();
    chk($sformatf("u%0d both second gnt", u), gnt_of(u, second), 1);
    drive(u, second, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk($sformatf("u%0d both second rvalid", u), rv_of(u, second), 1);
    chk($sformatf("u%0d both second rdata", u), rd_of(u, second), second ? dexp : cexp);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 3; u++) begin
      drive(u, 1'b0, 1'b1, 1'b1, 8'h55, 8'hFF);
      drive(u, 1'b1, 1'b1, 1'b1, 8'h66, 8'hEE);
    end

    // reset held with requests asserted
    repeat (3) begin
      tick();
      for (int u = 0; u < 3; u++) begin
        chk($sformatf("u%0d rst busy", u), busy[u], 0);
        chk($sformatf("u%0d rst mem_we", u), mem_we[u], 0);
        chk($sformatf("u%0d rst gnt", u), {cpu_gnt[u], dma_gnt[u]}, 0);
        chk($sformatf("u%0d rst rvalid", u), {cpu_rvalid[u], dma_rvalid[u]}, 0);
        chk($sformatf("u%0d rst rdata", u), {cpu_rdata[u], dma_rdata[u]}, 0);
        chk($sformatf("u%0d rst mem_addr", u), {mem_addr[u], mem_din[u]}, 0);
      end
    end
    for (int u = 0; u < 3; u++) begin
      drive(u, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(u, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    tick();
    reset = 1'b0;
    tick();

    // cpu write then read back
    wr(0, 1'b0, 8'h10, 8'hA5);
    rd(0, 1'b0, 8'h10, 8'hA5, 1);

    // contention, round robin
    wr(0, 1'b0, 8'h20, 8'hC3);
    wr(0, 1'b1, 8'h21, 8'h5A);
    both(0, 1'b0, 8'hC3, 8'h5A);
    wr(0, 1'b0, 8'h22, 8'h77);
    both(0, 1'b1, 8'hC3, 8'h5A);

    // cpu hammers, dma still gets in after one cpu access
    drive(0, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    chk("starve cpu gnt0", cpu_gnt[0], 1);
    drive(0, 1'b1, 1'b1, 1'b0, 8'h21, 8'h00);
    tick();
    chk("starve dma wait", dma_gnt[0], 0);
    tick();
    chk("starve cpu rvalid", cpu_rvalid[0], 1);
    chk("starve cpu rdata", cpu_rdata[0], 8'hC3);
    tick();
    chk("starve dma gnt", dma_gnt[0], 1);
    chk("starve cpu not gnt", cpu_gnt[0], 0);
    drive(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk("starve dma rvalid", dma_rvalid[0], 1);
    chk("starve dma rdata", dma_rdata[0], 8'h5A);
    tick();
    chk("starve cpu gnt1", cpu_gnt[0], 1);
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk("starve cpu rvalid1", cpu_rvalid[0], 1);
    tick();

    // reset during dma RWAIT
    drive(0, 1'b1, 1'b1, 1'b0, 8'h21, 8'h00);
    tick();
    chk("abort dma gnt", dma_gnt[0], 1);
    drive(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("abort in rwait", busy[0], 1);
    reset = 1'b1;
    #1;
    chk("abort async busy", busy[0], 0);
    tick();
    chk("abort no rvalid", dma_rvalid[0], 0);
    reset = 1'b0;
    repeat (2) begin
      tick();
      chk("abort still no rvalid", dma_rvalid[0], 0);
      chk("abort idle", busy[0], 0);
    end
    rd(0, 1'b0, 8'h10, 8'hA5, 1);

    // fixed priority unit: cpu wins regardless of history
    wr(1, 1'b0, 8'h20, 8'h11);
    wr(1, 1'b1, 8'h21, 8'h22);
    both(1, 1'b0, 8'h11, 8'h22);
    wr(1, 1'b0, 8'h30, 8'h33);
    both(1, 1'b0, 8'h11, 8'h22);

    // READ_LAT=3 unit
    wr(2, 1'b0, 8'h7F, 8'h3C);
    wr(2, 1'b1, 8'h11, 8'h99);
    rd(2, 1'b1, 8'h11, 8'h99, 3);
    rd(2, 1'b0, 8'h7F, 8'h3C, 3);
    chk("lat3 dma rdata kept", dma_rdata[2], 8'h99);
    chk("lat3 dma rvalid quiet", dma_rvalid[2], 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
